mpr_arbiter: RTL

MPR_ARBITER -- requirements
Module: mpr_arbiter

---
 rtl/mpr_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/mpr_arbiter.sv
// Four-client, two-port round-robin arbiter in front of a dual-port memory.
// Grants are combinational; responses come back one cycle after the grant edge.
module mpr_arbiter #(
    parameter int BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req_valid,
    input  logic [3:0]        req_we,
    input  logic [11:0]       req_addr,
    input  logic [4*BITS-1:0] req_wdata,
    output logic [3:0]        req_ready,
    output logic [3:0]        rsp_valid,
    output logic [4*BITS-1:0] rsp_rdata,
    output logic              we_a,
    output logic              we_b,
    output logic [2:0]        addr_a,
    output logic [2:0]        addr_b,
    output logic [BITS-1:0]   d_in_a,
    output logic [BITS-1:0]   d_in_b,
    input  logic [BITS-1:0]   d_out_a,
    input  logic [BITS-1:0]   d_out_b
);

    logic [1:0] ptr;
    logic       a_vld_p0;
    logic       b_vld_p0;
    logic [1:0] a_idx_p0;
    logic [1:0] b_idx_p0;
    logic [1:0] cand;
    logic [1:0] last_idx_p0;
    logic [3:0] grant_p0;

    function automatic logic [2:0] addr_sel(input logic [11:0] a, input logic [1:0] i);
        return a[int'(i)*3 +: 3];
    endfunction

    function automatic logic [BITS-1:0] wdata_sel(input logic [4*BITS-1:0] d, input logic [1:0] i);
        return d[int'(i)*BITS +: BITS];
    endfunction

    // Same address with any write on either side would make port B race port A.
    function automatic logic hazard(input logic [2:0] aa, input logic [2:0] ab,
                                    input logic wa, input logic wb);
        return (aa == ab) && (wa || wb);
    endfunction

    // Stage p0: combinational scan in priority order ptr, ptr+1, ptr+2, ptr+3
    always_comb begin
        a_vld_p0 = 1'b0;
        b_vld_p0 = 1'b0;
        a_idx_p0 = 2'd0;
        b_idx_p0 = 2'd0;
        cand     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (rst_n && req_valid[cand]) begin
                if (!a_vld_p0) begin
                    a_vld_p0 = 1'b1;
                    a_idx_p0 = cand;
                end else if (!b_vld_p0 &&
                             !hazard(addr_sel(req_addr, a_idx_p0), addr_sel(req_addr, cand),
                                     req_we[a_idx_p0], req_we[cand])) begin
                    b_vld_p0 = 1'b1;
                    b_idx_p0 = cand;
                end
            end
        end
    end

    assign last_idx_p0 = b_vld_p0 ? b_idx_p0 : a_idx_p0;
    assign grant_p0    = (a_vld_p0 ? (4'd1 << a_idx_p0) : 4'd0)
                       | (b_vld_p0 ? (4'd1 << b_idx_p0) : 4'd0);
    assign req_ready   = grant_p0;

    assign we_a   = a_vld_p0 & req_we[a_idx_p0];
    assign addr_a = a_vld_p0 ? addr_sel(req_addr, a_idx_p0) : 3'd0;
    assign d_in_a = a_vld_p0 ? wdata_sel(req_wdata, a_idx_p0) : '0;
    assign we_b   = b_vld_p0 & req_we[b_idx_p0];
    assign addr_b = b_vld_p0 ? addr_sel(req_addr, b_idx_p0) : 3'd0;
    assign d_in_b = b_vld_p0 ? wdata_sel(req_wdata, b_idx_p0) : '0;

    // Stage p1: capture pre-write memory data for each granted client
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 2'd0;
            rsp_valid <= 4'd0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= grant_p0;
            if (a_vld_p0) begin
                ptr <= last_idx_p0 + 2'd1;
                rsp_rdata[int'(a_idx_p0)*BITS +: BITS] <= d_out_a;
            end
            if (b_vld_p0) begin
                rsp_rdata[int'(b_idx_p0)*BITS +: BITS] <= d_out_b;
            end
        end
    end

endmodule
